// File: rtl/hazard_ctrl_if.sv
// Hazard-unit connection bundle: register indices and memory handshake in from the datapath,
// stall/flush enables and forwarding selects back out to it.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] Rs1D;
  logic [REG_AW-1:0] Rs2D;
  logic [REG_AW-1:0] Rs1E;
  logic [REG_AW-1:0] Rs2E;
  logic [REG_AW-1:0] RdE;
  logic [REG_AW-1:0] RdM;
  logic [REG_AW-1:0] RdW;
  logic              RegWriteM;
  logic              RegWriteW;
  logic              ResultSrcE0;
  logic              PCSrcE;
  logic              MemReqM;
  logic              MemReadyM;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              StallF;
  logic              StallD;
  logic              StallE;
  logic              StallM;
  logic              FlushD;
  logic              FlushE;
  logic              FlushW;
  logic              MemTimeout;
  logic              InWait;

  // Datapath side
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    input  FlushD, FlushE, FlushW, MemTimeout, InWait
  );

  // Hazard unit side
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
    output FlushD, FlushE, FlushW, MemTimeout, InWait
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for the 5-stage core: EX forwarding, load-use stall, branch flush and a
// memory-wait FSM with timeout watchdog. Define HAZARD_PERF_CNT_EN to add perf counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned TO_CNT_W    = 7
) (
  input  logic        clk,
  input  logic        rst,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] PerfLwStalls,
  output logic [31:0] PerfFlushes,
  output logic [31:0] PerfMemWait
`endif
);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  localparam logic [REG_AW-1:0]   RegZero = '0;
  localparam logic [TO_CNT_W-1:0] CntOne  = TO_CNT_W'(1);
  localparam logic [TO_CNT_W-1:0] CntLast = TO_CNT_W'(MEM_TIMEOUT - 1);

  state_e              stateQ, stateD;
  logic [TO_CNT_W-1:0] cntQ, cntD;
  logic                timeoutQ, timeoutD;

  logic memStall;
  logic lwStall;
  logic holdAll;
  logic brFlush;
  logic lwEff;

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] rs,
                                        input logic [REG_AW-1:0] rdM,
                                        input logic [REG_AW-1:0] rdW,
                                        input logic              wrM,
                                        input logic              wrW);
    logic [1:0] sel;
    sel = 2'b00;
    if (wrM && (rs != RegZero) && (rs == rdM)) begin
      sel = 2'b10;
    end else if (wrW && (rs != RegZero) && (rs == rdW)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign memStall = hz.MemReqM && !hz.MemReadyM;
  assign lwStall  = hz.ResultSrcE0 && (hz.RdE != RegZero) &&
                    ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

  // A frozen pipe must not lose the branch or the load: both are re-evaluated on release.
  assign holdAll = memStall || (stateQ == StErr);
  assign brFlush = !holdAll && hz.PCSrcE;
  assign lwEff   = !holdAll && !hz.PCSrcE && lwStall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ   <= StRun;
      cntQ     <= '0;
      timeoutQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      timeoutQ <= timeoutD;
    end
  end

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    timeoutD = timeoutQ;
    unique case (stateQ)
      StRun: begin
        if (memStall) begin
          stateD = StWait;
          cntD   = CntOne;
        end
      end
      StWait: begin
        // Leaving on !memStall also covers a request withdrawn without a ready.
        if (!memStall) begin
          stateD = StRun;
          cntD   = '0;
        end else if (cntQ == CntLast) begin
          stateD   = StErr;
          cntD     = cntQ + CntOne;
          timeoutD = 1'b1;
        end else begin
          cntD = cntQ + CntOne;
        end
      end
      StErr: begin
        timeoutD = 1'b1;
      end
      default: begin
        stateD = StRun;
        cntD   = '0;
      end
    endcase
  end

  always_comb begin
    hz.ForwardAE = 2'b00;
    hz.ForwardBE = 2'b00;
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushW    = 1'b0;
    if (!rst) begin
      hz.ForwardAE = fwdSel(hz.Rs1E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
      hz.ForwardBE = fwdSel(hz.Rs2E, hz.RdM, hz.RdW, hz.RegWriteM, hz.RegWriteW);
      if (holdAll) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.StallE = 1'b1;
        hz.StallM = 1'b1;
        hz.FlushW = 1'b1;
      end else if (brFlush) begin
        hz.FlushD = 1'b1;
        hz.FlushE = 1'b1;
      end else if (lwEff) begin
        hz.StallF = 1'b1;
        hz.StallD = 1'b1;
        hz.FlushE = 1'b1;
      end
    end
  end

  assign hz.MemTimeout = timeoutQ;
  assign hz.InWait     = (stateQ == StWait);

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perfLwQ, perfFlQ, perfMwQ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perfLwQ <= '0;
      perfFlQ <= '0;
      perfMwQ <= '0;
    end else begin
      if (lwEff && (perfLwQ != '1)) begin
        perfLwQ <= perfLwQ + 32'd1;
      end
      if (brFlush && (perfFlQ != '1)) begin
        perfFlQ <= perfFlQ + 32'd1;
      end
      if (memStall && (perfMwQ != '1)) begin
        perfMwQ <= perfMwQ + 32'd1;
      end
    end
  end

  assign PerfLwStalls = perfLwQ;
  assign PerfFlushes  = perfFlQ;
  assign PerfMemWait  = perfMwQ;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised successor to the pipeline's forwarding-only hazard logic for the 5-stage RISC-V core.
- Combines EX-stage operand forwarding with load-use stall detection and branch/jump flush.
- Adds a memory-wait stall FSM with a timeout watchdog.
- Sits beside the datapath. Drives the stall/flush enables of the F/D, D/E, E/M and M/W pipeline registers and the EX forwarding muxes.

Parameters:
- REG_AW, 5, register address width; register 0 is hard-wired zero.
- MEM_TIMEOUT, 64, max consecutive memory-wait cycles before timeout error (>=2).
- TO_CNT_W, 7, width of wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- Rs1D, Rs2D  in  REG_AW  source regs in Decode
- Rs1E, Rs2E  in  REG_AW  source regs in Execute
- RdE, RdM, RdW  in  REG_AW  dest regs in E/M/W
- RegWriteM, RegWriteW  in  1  write-back enables in M/W
- ResultSrcE0  in  1  instruction in Execute is a load
- PCSrcE  in  1  taken branch/jump resolved in Execute
- MemReqM  in  1  data memory access active in Memory stage
- MemReadyM  in  1  data memory completes this cycle
- ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
- StallF, StallD, StallE, StallM  out  1  hold pipeline register
- FlushD, FlushE, FlushW  out  1  insert bubble into register
- MemTimeout  out  1  sticky timeout error
- InWait  out  1  FSM in WAIT state

Behaviour:
- One clock domain, clk. Reset rst is asynchronous and active-high.
- While rst=1:
  - State=RUN, wait counter=0, MemTimeout=0.
  - All Stall*/Flush* outputs=0 and Forward*=00; these are gated by rst.
- Forwarding (combinational):
  - ForwardAE=10 if RegWriteM && Rs1E!=0 && Rs1E==RdM.
  - Else ForwardAE=01 if RegWriteW && Rs1E!=0 && Rs1E==RdW.
  - Else ForwardAE=00.
  - M has priority over W. ForwardBE follows the same rules with Rs2E.
- Load-use:
  - lwStall = ResultSrcE0 && RdE!=0 && (Rs1D==RdE || Rs2D==RdE).
  - lwStall asserts StallF, StallD and FlushE for exactly that cycle, giving a 1-cycle bubble.
- Branch: PCSrcE asserts FlushD and FlushE.
- memStall = MemReqM && !MemReadyM.
- FSM states RUN, WAIT, ERR:
  - RUN -> WAIT when memStall; counter loads 1.
  - WAIT: counter increments each cycle memStall holds.
  - WAIT -> RUN on MemReadyM; counter cleared.
  - WAIT -> ERR when counter==MEM_TIMEOUT-1 and memStall is still 1. MemTimeout is set in the same edge.
  - ERR is terminal until rst. MemTimeout stays 1.
- memStall (any state, including its first cycle) and the whole of ERR:
  - Assert StallF, StallD, StallE, StallM and FlushW.
  - Suppress FlushD/FlushE from PCSrcE and lwStall. The frozen branch/load is re-evaluated when the stall releases.
- Priority: ERR/memStall > PCSrcE > lwStall.
  - lwStall and PCSrcE together: FlushD=1, FlushE=1, StallF=0, StallD=0. The branch wins and the load-use stall is discarded.
- InWait=1 only in WAIT.
- Forward* is independent of stalls.
- Reset mid-wait returns to RUN immediately and asynchronously, with counter cleared.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds 32-bit output ports:
  - PerfLwStalls: cycles with effective lwStall.
  - PerfFlushes: cycles with PCSrcE-driven flush.
  - PerfMemWait: cycles with memStall.
- Counters reset to 0 on rst and saturate at 0xFFFFFFFF.
- When not defined, these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Forward priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=5 -> ForwardAE=10. With RegWriteM=0 -> 01. With Rs1E=RdM=RdW=0 -> 00.
- Load-use: ResultSrcE0=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for 1 cycle. With RdE=0 -> no stall.
- Branch vs load-use in same cycle: PCSrcE=1, lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then ready.
  - Stall F/D/E/M=1 and FlushW=1 for 3 cycles. InWait=1 from the 2nd cycle.
  - Returns to RUN after ready. MemTimeout=0.
- Timeout with MEM_TIMEOUT=4: MemReadyM held 0 -> MemTimeout=1 after the 4th wait cycle. Stalls persist until rst.
- Async reset mid-WAIT: rst pulsed between clock edges -> all outputs 0 immediately, counter 0, next cycle state RUN.
